bottle_fill_seq: RTL and testbench

//   Sequencer for the pill-bottling line. Counts pills into the current bottle and filled bottles,

---
 rtl/bottle_pkg.sv | 34 +++
 rtl/bcd2_counter.sv | 29 ++
 rtl/bottle_fill_seq.sv | 149 ++++++++++++++
 tb/tb_bottle_fill_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bottle_pkg.sv
// Shared types for the pill-bottling sequencer: FSM states, 2-digit BCD value, BCD increment.
package bottle_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned BCD2_W = 2 * BCD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] H;
        logic [BCD_W-1:0] L;
    } bcd2_t;

    localparam bcd2_t BCD_ZERO = bcd2_t'(8'h00);

    // Add one with ones->tens carry and 99->00 wrap.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.L == BCD_W'(9)) begin
            r.L = '0;
            r.H = (v.H == BCD_W'(9)) ? '0 : v.H + BCD_W'(1);
        end else begin
            r.L = v.L + BCD_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear (priority) and increment.
module bcd2_counter
    import bottle_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q_L,
    output logic [BCD_W-1:0] q_H
);

    bcd2_t q;

    // Count register: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_ZERO;
        end else if (clr) begin
            q <= BCD_ZERO;
        end else if (inc) begin
            q <= bcd2_inc(q);
        end
    end

    assign q_L = q.L;
    assign q_H = q.H;

endmodule

// File: rtl/bottle_fill_seq.sv
// Pill-bottling sequencer: counts pills per bottle and filled bottles in BCD, with bottle changeover.
module bottle_fill_seq
    import bottle_pkg::*;
#(
    parameter int unsigned SWAP_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             isWork,
    input  logic             start,
    input  logic             pill_pulse,
    input  logic [BCD_W-1:0] pill_maxL,
    input  logic [BCD_W-1:0] pill_maxH,
    input  logic [BCD_W-1:0] bot_maxL,
    input  logic [BCD_W-1:0] bot_maxH,
    output logic [BCD_W-1:0] pill_cnt_L,
    output logic [BCD_W-1:0] pill_cnt_H,
    output logic [BCD_W-1:0] bot_seq_L,
    output logic [BCD_W-1:0] bot_seq_H,
    output logic             bot_done,
    output logic             pill_lost,
    output logic             cfg_err,
    output logic             all_done
);

    localparam int unsigned SWAP_W = 4;

    state_t            state, state_n;
    logic [SWAP_W-1:0] swap_cnt, swap_cnt_n;
    bcd2_t             pill_tgt, pill_tgt_n;
    bcd2_t             bot_tgt, bot_tgt_n;
    bcd2_t             pill_cur, bot_cur, pill_nxt, bot_nxt;
    bcd2_t             pill_cfg, bot_cfg;
    logic              pill_clr, pill_inc, bot_clr, bot_inc;
    logic              bot_done_n, pill_lost_n, cfg_err_n;

    assign pill_cur = {pill_cnt_H, pill_cnt_L};
    assign bot_cur  = {bot_seq_H, bot_seq_L};
    assign pill_nxt = bcd2_inc(pill_cur);
    assign bot_nxt  = bcd2_inc(bot_cur);
    assign pill_cfg = {pill_maxH, pill_maxL};
    assign bot_cfg  = {bot_maxH, bot_maxL};

    // Pill count in the current bottle.
    bcd2_counter u_pill_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (pill_clr),
        .inc   (pill_inc),
        .q_L   (pill_cnt_L),
        .q_H   (pill_cnt_H)
    );

    // Filled-bottle count.
    bcd2_counter u_bot_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (bot_clr),
        .inc   (bot_inc),
        .q_L   (bot_seq_L),
        .q_H   (bot_seq_H)
    );

    // Next-state, counter control and pulse decode; isWork low overrides everything.
    always_comb begin
        state_n     = state;
        swap_cnt_n  = swap_cnt;
        pill_tgt_n  = pill_tgt;
        bot_tgt_n   = bot_tgt;
        pill_clr    = 1'b0;
        pill_inc    = 1'b0;
        bot_clr     = 1'b0;
        bot_inc     = 1'b0;
        bot_done_n  = 1'b0;
        pill_lost_n = 1'b0;
        cfg_err_n   = 1'b0;

        if (!isWork) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    pill_lost_n = pill_pulse;
                    if (start) begin
                        if (pill_cfg == BCD_ZERO || bot_cfg == BCD_ZERO) begin
                            cfg_err_n = 1'b1;
                        end else begin
                            pill_tgt_n = pill_cfg;
                            bot_tgt_n  = bot_cfg;
                            pill_clr   = 1'b1;
                            bot_clr    = 1'b1;
                            state_n    = FILL;
                        end
                    end
                end
                FILL: begin
                    if (pill_pulse) begin
                        if (pill_nxt == pill_tgt) begin
                            pill_clr   = 1'b1;
                            bot_inc    = 1'b1;
                            bot_done_n = 1'b1;
                            if (bot_nxt == bot_tgt) begin
                                state_n = DONE;
                            end else begin
                                state_n    = SWAP;
                                swap_cnt_n = SWAP_W'(SWAP_CYCLES - 1);
                            end
                        end else begin
                            pill_inc = 1'b1;
                        end
                    end
                end
                SWAP: begin
                    pill_lost_n = pill_pulse;
                    if (swap_cnt == '0) begin
                        state_n = FILL;
                    end else begin
                        swap_cnt_n = swap_cnt - SWAP_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, latched targets and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            swap_cnt  <= '0;
            pill_tgt  <= BCD_ZERO;
            bot_tgt   <= BCD_ZERO;
            bot_done  <= 1'b0;
            pill_lost <= 1'b0;
            cfg_err   <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            state     <= state_n;
            swap_cnt  <= swap_cnt_n;
            pill_tgt  <= pill_tgt_n;
            bot_tgt   <= bot_tgt_n;
            bot_done  <= bot_done_n;
            pill_lost <= pill_lost_n;
            cfg_err   <= cfg_err_n;
            all_done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_bottle_fill_seq.sv
// Testbench for bottle_fill_seq: vector table, directed corner sequences, randomized run vs model.
module tb_bottle_fill_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       isWork, start, pill_pulse;
    logic [3:0] pill_maxL, pill_maxH, bot_maxL, bot_maxH;
    logic [3:0] pill_cnt_L, pill_cnt_H, bot_seq_L, bot_seq_H;
    logic       bot_done, pill_lost, cfg_err, all_done;

    bottle_fill_seq #(.SWAP_CYCLES(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .isWork     (isWork),
        .start      (start),
        .pill_pulse (pill_pulse),
        .pill_maxL  (pill_maxL),
        .pill_maxH  (pill_maxH),
        .bot_maxL   (bot_maxL),
        .bot_maxH   (bot_maxH),
        .pill_cnt_L (pill_cnt_L),
        .pill_cnt_H (pill_cnt_H),
        .bot_seq_L  (bot_seq_L),
        .bot_seq_H  (bot_seq_H),
        .bot_done   (bot_done),
        .pill_lost  (pill_lost),
        .cfg_err    (cfg_err),
        .all_done   (all_done)
    );

    always #5 CLK = ~CLK;

    // Observed word: {pill count BCD, bottle count BCD, bot_done, pill_lost, cfg_err, all_done}
    logic [19:0] act;
    assign act = {pill_cnt_H, pill_cnt_L, bot_seq_H, bot_seq_L, bot_done, pill_lost, cfg_err, all_done};

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       wk, st, pp;
        logic [7:0] pm, bm;
        logic [7:0] ep, eb;
        logic       bd, pl, ce, ad;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic wk, st, pp, input logic [7:0] pm, bm, ep, eb,
                                input logic bd, pl, ce, ad);
        vec_t v;
        v.wk = wk; v.st = st; v.pp = pp; v.pm = pm; v.bm = bm;
        v.ep = ep; v.eb = eb; v.bd = bd; v.pl = pl; v.ce = ce; v.ad = ad;
        return v;
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] h, l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [19:0] ew(input int p, b, input logic bd, pl, ce, ad);
        return {int2bcd(p), int2bcd(b), bd, pl, ce, ad};
    endfunction

    task automatic chk(input string nm, input logic [19:0] a, input logic [19:0] e);
        n_checks++;
        if (a !== e) $display("FAIL %s: got %05h expected %05h", nm, a, e);
        else n_pass++;
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic drive(input logic wk, st, pp, input logic [7:0] pm, bm);
        isWork = wk; start = st; pill_pulse = pp;
        {pill_maxH, pill_maxL} = pm;
        {bot_maxH, bot_maxL}   = bm;
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: integer counts, phase and changeover time remaining.
    localparam int M_IDLE = 0, M_FILL = 1, M_SWAP = 2, M_DONE = 3;
    int m_mode, m_pills, m_bots, m_pt, m_bt, m_swap_left;
    logic [19:0] m_exp;

    task automatic mdl_reset();
        m_mode = M_IDLE; m_pills = 0; m_bots = 0; m_pt = 0; m_bt = 0; m_swap_left = 0;
        m_exp = '0;
    endtask

    task automatic mdl_step(input logic wk, st, pp, input logic [7:0] pm, bm);
        logic bd, pl, ce;
        bd = 1'b0; pl = 1'b0; ce = 1'b0;
        if (!wk) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
            pl = pp;
            if (st) begin
                if (bcd2int(pm) == 0 || bcd2int(bm) == 0) ce = 1'b1;
                else begin
                    m_pt = bcd2int(pm); m_bt = bcd2int(bm);
                    m_pills = 0; m_bots = 0; m_mode = M_FILL;
                end
            end
        end else if (m_mode == M_FILL) begin
            if (pp) begin
                m_pills++;
                if (m_pills == m_pt) begin
                    m_pills = 0;
                    m_bots  = (m_bots + 1) % 100;
                    bd = 1'b1;
                    if (m_bots == m_bt) m_mode = M_DONE;
                    else begin m_mode = M_SWAP; m_swap_left = 4; end
                end
            end
        end else begin
            pl = pp;
            m_swap_left--;
            if (m_swap_left == 0) m_mode = M_FILL;
        end
        m_exp = ew(m_pills, m_bots, bd, pl, ce, m_mode == M_DONE);
    endtask

    initial begin
        RST_N = 1'b0; isWork = 1'b0; start = 1'b0; pill_pulse = 1'b0;
        pill_maxL = '0; pill_maxH = '0; bot_maxL = '0; bot_maxH = '0;

        // pills=03, bottles=02 run, cfg_err, pill_lost, ignored start, isWork drop, restart
        tbl[0]  = mk(1'b1,1'b1,1'b0,8'h03,8'h00, 8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0);
        tbl[1]  = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h00, 1'b0,1'b1,1'b0,1'b0);
        tbl[2]  = mk(1'b1,1'b1,1'b0,8'h03,8'h02, 8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[3]  = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[4]  = mk(1'b1,1'b0,1'b0,8'h03,8'h02, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[5]  = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h02,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[6]  = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h01, 1'b1,1'b0,1'b0,1'b0);
        tbl[7]  = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h01, 1'b0,1'b1,1'b0,1'b0);
        tbl[8]  = mk(1'b1,1'b0,1'b0,8'h03,8'h02, 8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b1,1'b0,1'b0,8'h03,8'h02, 8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0);
        tbl[10] = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h01, 1'b0,1'b1,1'b0,1'b0);
        tbl[11] = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h01,8'h01, 1'b0,1'b0,1'b0,1'b0);
        tbl[12] = mk(1'b1,1'b1,1'b1,8'h03,8'h02, 8'h02,8'h01, 1'b0,1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h02, 1'b1,1'b0,1'b0,1'b1);
        tbl[14] = mk(1'b1,1'b0,1'b1,8'h03,8'h02, 8'h00,8'h02, 1'b0,1'b1,1'b0,1'b1);
        tbl[15] = mk(1'b1,1'b1,1'b0,8'h02,8'h01, 8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[16] = mk(1'b1,1'b0,1'b1,8'h02,8'h01, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[17] = mk(1'b0,1'b0,1'b1,8'h02,8'h01, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[18] = mk(1'b0,1'b1,1'b0,8'h02,8'h01, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[19] = mk(1'b1,1'b1,1'b0,8'h02,8'h01, 8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[20] = mk(1'b1,1'b0,1'b1,8'h02,8'h01, 8'h01,8'h00, 1'b0,1'b0,1'b0,1'b0);
        tbl[21] = mk(1'b1,1'b0,1'b1,8'h02,8'h01, 8'h00,8'h01, 1'b1,1'b0,1'b0,1'b1);

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state", act, 20'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].wk, tbl[i].st, tbl[i].pp, tbl[i].pm, tbl[i].bm);
            chk($sformatf("vec%0d", i), act,
                {tbl[i].ep, tbl[i].eb, tbl[i].bd, tbl[i].pl, tbl[i].ce, tbl[i].ad});
        end

        // pills=12: back-to-back pulses, ones carry 09->10, bottle on the 12th
        drive(1'b1, 1'b1, 1'b0, 8'h12, 8'h02);
        chk("p12_start", act, ew(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h12, 8'h02);
            if (i < 12) chk($sformatf("p12_pill%0d", i), act, ew(i, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            else        chk("p12_bottle", act, ew(0, 1, 1'b1, 1'b0, 1'b0, 1'b0));
        end

        // pulses during changeover are lost for exactly 4 clocks, then counted
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h12, 8'h02);
            if (i < 4) chk($sformatf("swap_lost%0d", i), act, ew(0, 1, 1'b0, 1'b1, 1'b0, 1'b0));
            else       chk("swap_refill", act, ew(1, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // async reset during SWAP clears everything at once
        drive(1'b0, 1'b0, 1'b0, 8'h01, 8'h05);
        drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h05);
        chk("rst_seq_start", act, ew(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h05);
        chk("rst_seq_bottle", act, ew(0, 1, 1'b1, 1'b0, 1'b0, 1'b0));
        isWork = 1'b1; start = 1'b0; pill_pulse = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst", act, 20'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
        chk("post_rst_start", act, ew(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h01);
        chk("post_rst_done", act, ew(0, 1, 1'b1, 1'b0, 1'b0, 1'b1));

        // randomized run against the behavioural model
        RST_N = 1'b0;
        #1;
        @(negedge CLK);
        RST_N = 1'b1;
        mdl_reset();
        for (int i = 0; i < 2000; i++) begin
            logic       wk, st, pp;
            logic [7:0] pm, bm;
            wk = ($urandom_range(0, 99) < 97);
            st = ($urandom_range(0, 19) == 0);
            pp = 1'($urandom_range(0, 1));
            pm = int2bcd(int'($urandom_range(0, 12)));
            bm = int2bcd(int'($urandom_range(0, 4)));
            mdl_step(wk, st, pp, pm, bm);
            drive(wk, st, pp, pm, bm);
            chk($sformatf("rand%0d", i), act, m_exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
